// File: rtl/cache_rd_arbiter_pkg.sv
// Shared types and constants for the cache read arbiter.
package cache_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        RET  = 2'd3
    } rd_arb_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

    localparam logic OWNER_ICACHE = 1'b0;
    localparam logic OWNER_DCACHE = 1'b1;

    function automatic logic [7:0] burst_len(input logic uncache, input int unsigned words);
        return uncache ? 8'd0 : 8'(words - 1);
    endfunction

endpackage

// File: rtl/cache_rd_arbiter_rd_line_buffer.sv
// Collects AXI read beats into a 128-bit line; uncached words land in the top lane.
module rd_line_buffer
    import cache_rd_arbiter_pkg::*;
#(
    parameter int LINE_WORD_NUM = 4
) (
    input  logic         clk_g,
    input  logic         reset,
    input  logic         start,
    input  logic         beat_we,
    input  logic         uncache,
    input  logic [31:0]  beat_data,
    output logic [127:0] line_data
);

    localparam int CW = (LINE_WORD_NUM > 1) ? $clog2(LINE_WORD_NUM) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [127:0]  line_q, line_d;

    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (start) begin
            cnt_d = '0;
        end else if (beat_we) begin
            if (uncache) begin
                line_d[127:96] = beat_data;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if ((k < LINE_WORD_NUM) && (cnt_q == CW'(k))) begin
                        line_d[32*k +: 32] = beat_data;
                    end
                end
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_g) begin
        if (reset) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            line_q <= line_d;
        end
    end

    assign line_data = line_q;

endmodule

// File: rtl/cache_rd_arbiter.sv
// Shares one AXI read channel between icache and dcache refills, one transaction at a time.
// CACHE_ARB_RR_EN selects round-robin tie-breaking; otherwise dcache wins ties.
//   state | meaning
//   IDLE  | waiting for a request; grant pulses rd_rdy
//   AR    | arvalid high, payload held until arready
//   R     | rready high, beats assembled until rlast
//   RET   | one-cycle ret_valid to the owner
module cache_rd_arbiter
    import cache_rd_arbiter_pkg::*;
#(
    parameter int LINE_WORD_NUM = 4,
    parameter int ID_WIDTH      = 4
) (
    input  logic                clk_g,
    input  logic                reset,

    input  logic                i_rd_req,
    input  logic                i_rd_uncache,
    input  logic [31:0]         i_rd_addr,
    output logic                i_rd_rdy,
    output logic                i_ret_valid,
    output logic [127:0]        i_ret_data,

    input  logic                d_rd_req,
    input  logic                d_rd_uncache,
    input  logic [31:0]         d_rd_addr,
    output logic                d_rd_rdy,
    output logic                d_ret_valid,
    output logic [127:0]        d_ret_data,

    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,

    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    rd_arb_state_t state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic          uncache_q, uncache_d;
    logic          owner_q, owner_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic          i_ret_valid_q, i_ret_valid_d;
    logic          d_ret_valid_q, d_ret_valid_d;

    logic          gnt_any;
    logic          gnt_owner;
    logic [127:0]  line_data;

`ifdef CACHE_ARB_RR_EN
    logic          last_q, last_d;
`endif

    always_comb begin
        gnt_any = (state_q == IDLE) && (i_rd_req || d_rd_req);
        if (i_rd_req && d_rd_req) begin
`ifdef CACHE_ARB_RR_EN
            gnt_owner = (last_q == OWNER_DCACHE) ? OWNER_ICACHE : OWNER_DCACHE;
`else
            gnt_owner = OWNER_DCACHE;
`endif
        end else if (d_rd_req) begin
            gnt_owner = OWNER_DCACHE;
        end else begin
            gnt_owner = OWNER_ICACHE;
        end
    end

    assign i_rd_rdy = gnt_any && (gnt_owner == OWNER_ICACHE);
    assign d_rd_rdy = gnt_any && (gnt_owner == OWNER_DCACHE);

`ifdef CACHE_ARB_RR_EN
    always_comb begin
        last_d = last_q;
        if (gnt_any) begin
            last_d = gnt_owner;
        end
    end

    always_ff @(posedge clk_g) begin
        if (reset) begin
            last_q <= OWNER_ICACHE;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        uncache_d     = uncache_q;
        owner_d       = owner_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        i_ret_valid_d = 1'b0;
        d_ret_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    owner_d   = gnt_owner;
                    addr_d    = (gnt_owner == OWNER_DCACHE) ? d_rd_addr : i_rd_addr;
                    uncache_d = (gnt_owner == OWNER_DCACHE) ? d_rd_uncache : i_rd_uncache;
                    arvalid_d = 1'b1;
                    state_d   = AR;
                end
            end
            AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = R;
                end
            end
            R: begin
                // rlast ends the burst even if the beat count disagrees
                if (rvalid && rlast) begin
                    rready_d      = 1'b0;
                    i_ret_valid_d = (owner_q == OWNER_ICACHE);
                    d_ret_valid_d = (owner_q == OWNER_DCACHE);
                    state_d       = RET;
                end
            end
            RET: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_g) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            uncache_q     <= 1'b0;
            owner_q       <= OWNER_ICACHE;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            i_ret_valid_q <= 1'b0;
            d_ret_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            uncache_q     <= uncache_d;
            owner_q       <= owner_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            i_ret_valid_q <= i_ret_valid_d;
            d_ret_valid_q <= d_ret_valid_d;
        end
    end

    rd_line_buffer #(
        .LINE_WORD_NUM (LINE_WORD_NUM)
    ) u_line_buffer (
        .clk_g     (clk_g),
        .reset     (reset),
        .start     (gnt_any),
        .beat_we   ((state_q == R) && rvalid),
        .uncache   (uncache_q),
        .beat_data (rdata),
        .line_data (line_data)
    );

    // Response code and ID carry no information for a single-outstanding master.
    logic unused_rsp;
    assign unused_rsp = ^{rid, rresp};

    assign arid        = {{(ID_WIDTH-1){1'b0}}, owner_q};
    assign araddr      = addr_q;
    assign arlen       = burst_len(uncache_q, LINE_WORD_NUM);
    assign arsize      = AXI_SIZE_WORD;
    assign arburst     = AXI_BURST_INCR;
    assign arvalid     = arvalid_q;
    assign rready      = rready_q;
    assign i_ret_valid = i_ret_valid_q;
    assign d_ret_valid = d_ret_valid_q;
    assign i_ret_data  = line_data;
    assign d_ret_data  = line_data;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Directed bench for cache_rd_arbiter; expectations follow CACHE_ARB_RR_EN when defined.
module tb_cache_rd_arbiter;
    import cache_rd_arbiter_pkg::*;

    logic         clk_g = 1'b0;
    logic         reset;
    logic         i_rd_req, i_rd_uncache, i_rd_rdy, i_ret_valid;
    logic [31:0]  i_rd_addr;
    logic [127:0] i_ret_data;
    logic         d_rd_req, d_rd_uncache, d_rd_rdy, d_ret_valid;
    logic [31:0]  d_rd_addr;
    logic [127:0] d_ret_data;
    logic [3:0]   arid, rid;
    logic [31:0]  araddr, rdata;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst, rresp;
    logic         arvalid, arready, rlast, rvalid, rready;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    cache_rd_arbiter #(.LINE_WORD_NUM(4), .ID_WIDTH(4)) dut (
        .clk_g(clk_g), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_uncache(i_rd_uncache), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_uncache(d_rd_uncache), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk_g = ~clk_g;
    always @(posedge clk_g) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: sim time expired, required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic              is_d;
        logic              unc;
        logic [31:0]       addr;
        logic [3:0][31:0]  beats;
        int                ar_dly;
        int                gap;
        logic [1:0]        resp;
        logic [7:0]        exp_len;
        int                exp_lat;
        logic [127:0]      exp_data;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered at the negedge of the first cycle after the grant, owner already chosen.
    task automatic finish_txn(input vec_t v, input int start);
        int n;
        logic own_ret, oth_ret, oth_rdy;
        n = v.unc ? 1 : 4;
        for (int d = 0; d <= v.ar_dly; d++) begin
            if (d > 0) @(negedge clk_g);
            arready = (d == v.ar_dly);
            #1;
            check("arvalid", 128'(arvalid), 128'(1'b1));
            check("araddr", 128'(araddr), 128'(v.addr));
            check("arlen", 128'(arlen), 128'(v.exp_len));
            if (d == 0) begin
                check("arid", 128'(arid), 128'({3'b000, v.is_d}));
                check("arsize", 128'(arsize), 128'(3'b010));
                check("arburst", 128'(arburst), 128'(2'b01));
            end
        end
        @(negedge clk_g);
        arready = 1'b0;
        for (int k = 0; k < n; k++) begin
            rvalid = 1'b1;
            rdata  = v.beats[k];
            rlast  = (k == n - 1);
            rresp  = v.resp;
            rid    = 4'hF;
            #1;
            check("rready", 128'(rready), 128'(1'b1));
            @(negedge clk_g);
            rvalid = 1'b0;
            rlast  = 1'b0;
            if (k < n - 1) repeat (v.gap) @(negedge clk_g);
        end
        #1;
        own_ret = v.is_d ? d_ret_valid : i_ret_valid;
        oth_ret = v.is_d ? i_ret_valid : d_ret_valid;
        oth_rdy = v.is_d ? i_rd_rdy : d_rd_rdy;
        check("ret_valid_owner", 128'(own_ret), 128'(1'b1));
        check("ret_valid_other", 128'(oth_ret), 128'(1'b0));
        check("rdy_in_ret", 128'(oth_rdy), 128'(1'b0));
        check("latency", 128'(cyc - start), 128'(v.exp_lat));
        if (v.unc)
            check("ret_word", 128'((v.is_d ? d_ret_data : i_ret_data) >> 96), 128'(v.exp_data >> 96));
        else
            check("ret_line", v.is_d ? d_ret_data : i_ret_data, v.exp_data);
        @(negedge clk_g);
        #1;
        check("ret_one_cycle", 128'({i_ret_valid, d_ret_valid}), 128'(2'b00));
    endtask

    task automatic run_vec(input vec_t v);
        int start;
        @(negedge clk_g);
        if (v.is_d) begin
            d_rd_req = 1'b1; d_rd_uncache = v.unc; d_rd_addr = v.addr;
        end else begin
            i_rd_req = 1'b1; i_rd_uncache = v.unc; i_rd_addr = v.addr;
        end
        #1;
        check("grant_rdy", 128'({i_rd_rdy, d_rd_rdy}), 128'(v.is_d ? 2'b01 : 2'b10));
        start = cyc;
        @(negedge clk_g);
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        finish_txn(v, start);
    endtask

    initial begin
        vec_t vt;
        int   start;
        logic second_is_d;

        vecs[0] = '{1'b0, 1'b0, 32'h1FC0_0010, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
                    0, 0, 2'b00, 8'd3, 6, 128'h000000A3_000000A2_000000A1_000000A0};
        vecs[1] = '{1'b1, 1'b1, 32'hBFAF_8004, {32'h0, 32'h0, 32'h0, 32'h1234_5678},
                    0, 0, 2'b00, 8'd0, 3, {32'h1234_5678, 96'h0}};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_1000, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                    5, 2, 2'b10, 8'd3, 17, 128'h44444444_33333333_22222222_11111111};
        vecs[3] = '{1'b0, 1'b1, 32'h0040_0004, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF},
                    2, 0, 2'b11, 8'd0, 5, {32'hDEAD_BEEF, 96'h0}};

        reset = 1'b1;
        i_rd_req = 1'b0; i_rd_uncache = 1'b0; i_rd_addr = '0;
        d_rd_req = 1'b0; d_rd_uncache = 1'b0; d_rd_addr = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        repeat (3) @(negedge clk_g);
        #1;
        check("rst_arvalid_rready", 128'({arvalid, rready}), 128'(2'b00));
        check("rst_ret_valid", 128'({i_ret_valid, d_ret_valid}), 128'(2'b00));
        check("rst_line", i_ret_data, 128'h0);
        reset = 1'b0;

        for (int t = 0; t < 4; t++) run_vec(vecs[t]);

        // Two ties back to back.
        vt = '{1'b1, 1'b1, 32'h0000_0200, {32'h0, 32'h0, 32'h0, 32'h5555_AAAA},
               0, 0, 2'b00, 8'd0, 3, {32'h5555_AAAA, 96'h0}};
        @(negedge clk_g);
        i_rd_req = 1'b1; i_rd_uncache = 1'b1; i_rd_addr = 32'h0000_0100;
        d_rd_req = 1'b1; d_rd_uncache = 1'b1; d_rd_addr = 32'h0000_0200;
        #1;
        check("tie1_rdy", 128'({i_rd_rdy, d_rd_rdy}), 128'(2'b01));
        start = cyc;
        @(negedge clk_g);
        d_rd_req = 1'b0;
        finish_txn(vt, start);
        d_rd_req = 1'b1;
        #1;
`ifdef CACHE_ARB_RR_EN
        second_is_d = 1'b0;
`else
        second_is_d = 1'b1;
`endif
        check("tie2_rdy", 128'({i_rd_rdy, d_rd_rdy}), 128'(second_is_d ? 2'b01 : 2'b10));
        start = cyc;
        vt.is_d     = second_is_d;
        vt.addr     = second_is_d ? 32'h0000_0200 : 32'h0000_0100;
        vt.beats[0] = 32'h0BAD_F00D;
        vt.exp_data = {32'h0BAD_F00D, 96'h0};
        @(negedge clk_g);
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        finish_txn(vt, start);

        // Reset in R after two beats.
        @(negedge clk_g);
        i_rd_req = 1'b1; i_rd_uncache = 1'b0; i_rd_addr = 32'h1FC0_0040;
        @(negedge clk_g);
        i_rd_req = 1'b0; arready = 1'b1;
        @(negedge clk_g);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_0000; rlast = 1'b0;
        @(negedge clk_g);
        rdata = 32'hCAFE_0001;
        @(negedge clk_g);
        rvalid = 1'b0;
        reset  = 1'b1;
        @(negedge clk_g);
        reset = 1'b0;
        #1;
        check("mid_rst_rready", 128'(rready), 128'(1'b0));
        check("mid_rst_state", 128'(dut.state_q), 128'(IDLE));
        check("mid_rst_ret", 128'({i_ret_valid, d_ret_valid}), 128'(2'b00));
        check("mid_rst_line", i_ret_data, 128'h0);
        @(negedge clk_g);
        #1;
        check("mid_rst_ret2", 128'({i_ret_valid, d_ret_valid, arvalid}), 128'(3'b000));
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
